// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm sequencer: FSM encoding, timer width,
// timing defaults and the hour/minute match helper.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } alarm_state_e;

    localparam int TIMER_W = 9;
    typedef logic [TIMER_W-1:0] timer_t;

    localparam int RING_TIMEOUT_S_DEF = 60;
    localparam int SNOOZE_S_DEF       = 300;
    localparam int MAX_SNOOZE_DEF     = 3;

    function automatic logic time_match(input logic [5:0] t_hour, input logic [5:0] t_min,
                                        input logic [5:0] a_hour, input logic [5:0] a_min);
        return {t_hour, t_min} == {a_hour, a_min};
    endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the clock/UI logic (master) and the alarm sequencer (slave).
interface alarm_sequencer_if;

    logic       tick_1s;
    logic       beep_tick;
    logic [5:0] THour;
    logic [5:0] TMin;
    logic [5:0] sec;
    logic [5:0] AHour;
    logic [5:0] AMin;
    logic       Alarm_ON;
    logic       Time;
    logic       Snooze;
    logic       Stop;
    logic       Ring;
    logic       Buzz;
    logic       Snoozing;
    logic [1:0] SnzCnt;
    logic       Missed;

    modport master (
        output tick_1s, beep_tick, THour, TMin, sec, AHour, AMin,
               Alarm_ON, Time, Snooze, Stop,
        input  Ring, Buzz, Snoozing, SnzCnt, Missed
    );

    modport slave (
        input  tick_1s, beep_tick, THour, TMin, sec, AHour, AMin,
               Alarm_ON, Time, Snooze, Stop,
        output Ring, Buzz, Snoozing, SnzCnt, Missed
    );

endinterface

// File: rtl/sec_countdown.sv
// Seconds down-counter: load wins over decrement, decrement stops at zero.
// zero_o/one_o let the owner detect the tick that finishes the count.
module sec_countdown
    import alarm_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   load_i,
    input  timer_t load_val_i,
    input  logic   dec_i,
    output logic   zero_o,
    output logic   one_o
);

    timer_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - timer_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
    assign one_o  = (count_q == timer_t'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze sequencer: triggers on the first second of the alarm minute,
// rings with a beep-gated buzzer, and handles snooze, stop and ring timeout.
//
//   state     | meaning
//   ST_IDLE   | waiting for the alarm minute (sec == 0 tick)
//   ST_RING   | ringing, ring timer counting down, buzzer toggling
//   ST_SNOOZE | silenced, snooze timer counting down to re-ring
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = RING_TIMEOUT_S_DEF,
    parameter int SNOOZE_S       = SNOOZE_S_DEF,
    parameter int MAX_SNOOZE     = MAX_SNOOZE_DEF
) (
    input  logic               masCLK,
    input  logic               Reset,
    alarm_sequencer_if.slave   bus
);

    localparam timer_t     RING_LOAD = timer_t'(RING_TIMEOUT_S);
    localparam timer_t     SNZ_LOAD  = timer_t'(SNOOZE_S);
    localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

    alarm_state_e state_q, state_d;
    logic [1:0]   snzcnt_q, snzcnt_d;
    logic         missed_q, missed_d;
    logic         ring_q, ring_d;
    logic         buzz_q, buzz_d;
    logic         snoozing_q, snoozing_d;

    logic ring_load, snz_load;
    logic ring_zero, ring_one, snz_zero, snz_one;
    logic trigger, ring_expire, snz_expire;

    sec_countdown u_ring_timer (
        .clk_i      (masCLK),
        .rst_i      (Reset),
        .load_i     (ring_load),
        .load_val_i (RING_LOAD),
        .dec_i      (bus.tick_1s && (state_q == ST_RING)),
        .zero_o     (ring_zero),
        .one_o      (ring_one)
    );

    sec_countdown u_snooze_timer (
        .clk_i      (masCLK),
        .rst_i      (Reset),
        .load_i     (snz_load),
        .load_val_i (SNZ_LOAD),
        .dec_i      (bus.tick_1s && (state_q == ST_SNOOZE)),
        .zero_o     (snz_zero),
        .one_o      (snz_one)
    );

    assign trigger = bus.tick_1s && bus.Alarm_ON && !bus.Time && (bus.sec == 6'd0) &&
                     time_match(bus.THour, bus.TMin, bus.AHour, bus.AMin);
    // A timer expires on the tick that would take it to zero (or if already zero).
    assign ring_expire = bus.tick_1s && (ring_zero || ring_one);
    assign snz_expire  = bus.tick_1s && (snz_zero || snz_one);

    always_ff @(posedge masCLK) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            snzcnt_q   <= '0;
            missed_q   <= 1'b0;
            ring_q     <= 1'b0;
            buzz_q     <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            snzcnt_q   <= snzcnt_d;
            missed_q   <= missed_d;
            ring_q     <= ring_d;
            buzz_q     <= buzz_d;
            snoozing_q <= snoozing_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        snzcnt_d  = snzcnt_q;
        missed_d  = missed_q;
        ring_load = 1'b0;
        snz_load  = 1'b0;
        if (bus.Stop) begin
            state_d  = ST_IDLE;
            missed_d = 1'b0;
            if (state_q != ST_IDLE) begin
                snzcnt_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        state_d   = ST_RING;
                        ring_load = 1'b1;
                        snzcnt_d  = '0;
                        missed_d  = 1'b0;
                    end
                end
                ST_RING: begin
                    if (!bus.Alarm_ON) begin
                        state_d  = ST_IDLE;
                        snzcnt_d = '0;
                    end else if (bus.Snooze && (snzcnt_q < SNZ_MAX)) begin
                        state_d  = ST_SNOOZE;
                        snz_load = 1'b1;
                        snzcnt_d = snzcnt_q + 2'd1;
                    end else if (ring_expire) begin
                        state_d  = ST_IDLE;
                        missed_d = 1'b1;
                    end
                end
                ST_SNOOZE: begin
                    if (!bus.Alarm_ON) begin
                        state_d  = ST_IDLE;
                        snzcnt_d = '0;
                    end else if (snz_expire) begin
                        state_d   = ST_RING;
                        ring_load = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ring_d     = (state_d == ST_RING);
        snoozing_d = (state_d == ST_SNOOZE);
        buzz_d     = 1'b0;
        // Buzzer starts low on every entry to RING, then follows beep_tick.
        if ((state_d == ST_RING) && (state_q == ST_RING)) begin
            buzz_d = buzz_q ^ bus.beep_tick;
        end
    end

    assign bus.Ring     = ring_q;
    assign bus.Buzz     = buzz_q;
    assign bus.Snoozing = snoozing_q;
    assign bus.SnzCnt   = snzcnt_q;
    assign bus.Missed   = missed_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed vector table, long timer sequences and
// random stimulus, all compared against a behavioural model of the alarm rules.
module tb_alarm_sequencer;

    localparam int       RT = 60;
    localparam int       ST = 300;
    localparam int       MS = 3;
    localparam bit [5:0] AH = 6'd7;
    localparam bit [5:0] AM = 6'd30;

    logic masCLK = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    alarm_sequencer_if bus();

    alarm_sequencer #(
        .RING_TIMEOUT_S (RT),
        .SNOOZE_S       (ST),
        .MAX_SNOOZE     (MS)
    ) dut (
        .masCLK (masCLK),
        .Reset  (Reset),
        .bus    (bus.slave)
    );

    always #5 masCLK = ~masCLK;

    // Model: mode 0 idle, 1 ringing, 2 snoozing; timers kept as elapsed seconds.
    int m_mode = 0;
    int m_ring_elapsed = 0;
    int m_snz_elapsed = 0;
    int m_used = 0;
    bit m_missed = 1'b0;
    bit m_buzz = 1'b0;

    task automatic model_step(input bit rst, input bit tick, input bit beep, input bit match,
                              input bit sec0, input bit on, input bit tm,
                              input bit snz, input bit stp);
        int prev;
        prev = m_mode;
        if (rst) begin
            m_mode = 0; m_ring_elapsed = 0; m_snz_elapsed = 0;
            m_used = 0; m_missed = 1'b0; m_buzz = 1'b0;
            return;
        end
        if (stp) begin
            if (m_mode != 0) m_used = 0;
            m_mode = 0;
            m_missed = 1'b0;
        end else if (!on && m_mode != 0) begin
            m_mode = 0;
            m_used = 0;
        end else if (m_mode == 1 && snz && m_used < MS) begin
            m_mode = 2;
            m_used++;
            m_snz_elapsed = 0;
        end else if (m_mode == 1 && tick) begin
            m_ring_elapsed++;
            if (m_ring_elapsed >= RT) begin
                m_mode = 0;
                m_missed = 1'b1;
            end
        end else if (m_mode == 2 && tick) begin
            m_snz_elapsed++;
            if (m_snz_elapsed >= ST) begin
                m_mode = 1;
                m_ring_elapsed = 0;
            end
        end else if (m_mode == 0 && tick && on && !tm && match && sec0) begin
            m_mode = 1;
            m_ring_elapsed = 0;
            m_used = 0;
            m_missed = 1'b0;
        end
        m_buzz = (m_mode == 1 && prev == 1) ? (m_buzz ^ beep) : 1'b0;
    endtask

    function automatic bit [5:0] dut_outs();
        return {bus.Ring, bus.Buzz, bus.Snoozing, bus.SnzCnt, bus.Missed};
    endfunction

    function automatic bit [5:0] model_outs();
        return {m_mode == 1, m_buzz, m_mode == 2, 2'(m_used), m_missed};
    endfunction

    task automatic check(input string name, input bit [5:0] act, input bit [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {Ring,Buzz,Snoozing,SnzCnt,Missed}=%b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit rst, input bit tick, input bit beep,
                         input bit [5:0] h, input bit [5:0] m, input bit [5:0] s,
                         input bit on, input bit tm, input bit snz, input bit stp);
        Reset         = rst;
        bus.tick_1s   = tick;
        bus.beep_tick = beep;
        bus.THour     = h;
        bus.TMin      = m;
        bus.sec       = s;
        bus.Alarm_ON  = on;
        bus.Time      = tm;
        bus.Snooze    = snz;
        bus.Stop      = stp;
        model_step(rst, tick, beep, (h == AH) && (m == AM), s == 6'd0, on, tm, snz, stp);
        @(posedge masCLK);
        #1;
        check("model", dut_outs(), model_outs());
    endtask

    task automatic idle_cycle();
        apply(0, 0, 0, AH, AM, 6'd1, 1, 0, 0, 0);
    endtask

    task automatic fire();
        apply(0, 1, 0, AH, AM, 6'd0, 1, 0, 0, 0);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            apply(0, 1, 0, AH, AM, 6'(1 + (i % 58)), 1, 0, 0, 0);
            idle_cycle();
        end
    endtask

    typedef struct {
        bit       rst, tick, beep;
        bit [5:0] h, m, s;
        bit       on, tm, snz, stp;
        bit [5:0] exp;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.AHour = AH;
        bus.AMin  = AM;

        //           rst tick beep  h    m    s   on tm snz stp  {Ring,Buzz,Snz,Cnt,Missed}
        vecs[0]  = '{1, 0, 0, AH, AM, 6'd0,  1, 0, 0, 0, 6'b000000};
        vecs[1]  = '{0, 1, 0, AH, AM, 6'd0,  1, 1, 0, 0, 6'b000000};
        vecs[2]  = '{0, 1, 0, AH, AM, 6'd5,  1, 0, 0, 0, 6'b000000};
        vecs[3]  = '{0, 1, 0, AH, 6'd31, 6'd0, 1, 0, 0, 0, 6'b000000};
        vecs[4]  = '{0, 1, 0, AH, AM, 6'd0,  0, 0, 0, 0, 6'b000000};
        vecs[5]  = '{0, 1, 0, AH, AM, 6'd0,  1, 0, 0, 0, 6'b100000};
        vecs[6]  = '{0, 0, 1, AH, AM, 6'd1,  1, 0, 0, 0, 6'b110000};
        vecs[7]  = '{0, 0, 1, AH, AM, 6'd1,  1, 0, 0, 0, 6'b100000};
        vecs[8]  = '{0, 0, 0, AH, AM, 6'd1,  1, 0, 1, 0, 6'b001010};
        vecs[9]  = '{0, 0, 0, AH, AM, 6'd1,  1, 0, 1, 0, 6'b001010};
        vecs[10] = '{0, 0, 0, AH, AM, 6'd1,  0, 0, 0, 0, 6'b000000};
        vecs[11] = '{0, 1, 0, AH, AM, 6'd0,  1, 0, 0, 0, 6'b100000};
        vecs[12] = '{0, 0, 1, AH, AM, 6'd1,  1, 0, 0, 0, 6'b110000};
        vecs[13] = '{0, 0, 0, AH, AM, 6'd1,  1, 0, 1, 1, 6'b000000};
        vecs[14] = '{0, 0, 0, AH, AM, 6'd1,  1, 0, 0, 1, 6'b000000};

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].rst, vecs[i].tick, vecs[i].beep, vecs[i].h, vecs[i].m, vecs[i].s,
                  vecs[i].on, vecs[i].tm, vecs[i].snz, vecs[i].stp);
            check($sformatf("vec%0d", i), dut_outs(), vecs[i].exp);
        end

        // Ring timeout after exactly RT ticks, then Stop in idle clears Missed.
        fire();
        check("trigger", dut_outs(), 6'b100000);
        run_ticks(RT - 1);
        check("ring_before_timeout", dut_outs(), 6'b100000);
        run_ticks(1);
        check("ring_timeout", dut_outs(), 6'b000001);
        apply(0, 0, 0, AH, AM, 6'd1, 1, 0, 0, 1);
        check("stop_idle_clears_missed", dut_outs(), 6'b000000);

        // Snooze, re-ring after ST ticks, buzzer restarts low then toggles.
        fire();
        apply(0, 0, 0, AH, AM, 6'd1, 1, 0, 1, 0);
        check("snooze1", dut_outs(), 6'b001010);
        run_ticks(ST - 1);
        check("snooze_before_expiry", dut_outs(), 6'b001010);
        run_ticks(1);
        check("re_ring", dut_outs(), 6'b100010);
        apply(0, 0, 1, AH, AM, 6'd1, 1, 0, 0, 0);
        check("buzz_toggle_on", dut_outs(), 6'b110010);
        apply(0, 0, 1, AH, AM, 6'd1, 1, 0, 0, 0);
        check("buzz_toggle_off", dut_outs(), 6'b100010);

        // Use up the remaining snoozes; the one past the limit is ignored.
        for (int k = 2; k <= MS; k++) begin
            apply(0, 0, 0, AH, AM, 6'd1, 1, 0, 1, 0);
            check($sformatf("snooze%0d", k), dut_outs(), {3'b001, 2'(k), 1'b0});
            run_ticks(ST);
        end
        check("ring_after_max", dut_outs(), 6'b100110);
        apply(0, 0, 0, AH, AM, 6'd1, 1, 0, 1, 0);
        check("snooze_ignored", dut_outs(), 6'b100110);
        apply(0, 0, 0, AH, AM, 6'd1, 1, 0, 0, 1);
        check("stop_ring", dut_outs(), 6'b000000);

        // Reset mid-ring at 25 s remaining; no re-trigger later in the same minute.
        fire();
        run_ticks(RT - 25);
        check("ring_at_25", dut_outs(), 6'b100000);
        apply(1, 1, 1, AH, AM, 6'd0, 1, 0, 1, 0);
        check("reset_mid_ring", dut_outs(), 6'b000000);
        run_ticks(10);
        check("no_retrigger_after_reset", dut_outs(), 6'b000000);

        // Alarm_ON drop during snooze forces idle.
        fire();
        apply(0, 0, 0, AH, AM, 6'd1, 1, 0, 1, 0);
        apply(0, 1, 0, AH, AM, 6'd2, 0, 0, 0, 0);
        check("alarm_off_in_snooze", dut_outs(), 6'b000000);

        // Random stimulus against the model.
        begin
            bit on_lvl;
            on_lvl = 1'b1;
            for (int i = 0; i < 4000; i++) begin
                bit [5:0] h, m, s;
                if ($urandom_range(0, 299) == 0) on_lvl = ~on_lvl;
                case ($urandom_range(0, 9))
                    0:       begin h = AH;    m = 6'd31; end
                    1:       begin h = 6'd8;  m = AM;    end
                    default: begin h = AH;    m = AM;    end
                endcase
                s = 6'($urandom_range(0, 2));
                apply($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 2) == 0, h, m, s, on_lvl,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0,
                      $urandom_range(0, 299) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 SHALL have parameter RING_TIMEOUT_S, default 60, seconds of ringing before auto-stop.
REQ-002 SHALL have parameter SNOOZE_S, default 300, snooze duration in seconds.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event.
REQ-004 SHALL have port masCLK  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port tick_1s  input  1  one-cycle pulse once per second, masCLK domain.
REQ-007 SHALL have port beep_tick  input  1  one-cycle pulse at beep-pattern rate, masCLK domain.
REQ-008 SHALL have ports THour, TMin, sec  input  6 each  current time.
REQ-009 SHALL have ports AHour, AMin  input  6 each  alarm setting.
REQ-010 SHALL have port Alarm_ON  input  1  alarm enable level.
REQ-011 SHALL have port Time  input  1  time-set mode level; high suppresses triggering.
REQ-012 SHALL have ports Snooze, Stop  input  1 each  debounced one-cycle button pulses.
REQ-013 SHALL have port Ring  output  1  high in RING state.
REQ-014 SHALL have port Buzz  output  1  buzzer drive, gated beep pattern.
REQ-015 SHALL have port Snoozing  output  1  high in SNOOZE state.
REQ-016 SHALL have port SnzCnt  output  2  snoozes used in current event.
REQ-017 SHALL have port Missed  output  1  sticky flag: last event ended by timeout.

Function
REQ-018 SHALL implement FSM states IDLE, RING, SNOOZE; all outputs registered, updated one masCLK cycle after the causing input.
REQ-019 Trigger SHALL be: IDLE and tick_1s and Alarm_ON and !Time and {THour,TMin}=={AHour,AMin} and sec==0 -> RING, ring timer loaded with RING_TIMEOUT_S, SnzCnt=0, Missed=0.
REQ-020 In IDLE, a matching minute with sec!=0 SHALL NOT trigger (one trigger per match minute).
REQ-021 In RING, each tick_1s SHALL decrement ring timer; on reaching 0 -> IDLE, Missed=1.
REQ-022 In RING, Snooze with SnzCnt<MAX_SNOOZE SHALL go to SNOOZE, load snooze timer with SNOOZE_S, SnzCnt+1.
REQ-023 In RING, Snooze with SnzCnt==MAX_SNOOZE SHALL be ignored.
REQ-024 In SNOOZE, each tick_1s SHALL decrement snooze timer; on reaching 0 -> RING, ring timer reloaded with RING_TIMEOUT_S.
REQ-025 Stop in RING or SNOOZE SHALL go to IDLE, Missed=0, SnzCnt=0; Stop in IDLE SHALL clear Missed only.
REQ-026 Alarm_ON low in RING or SNOOZE SHALL force IDLE, SnzCnt=0, Missed unchanged.
REQ-027 Same-cycle priority SHALL be: Stop > Alarm_ON low > Snooze > timer expiry > trigger.
REQ-028 Buzz SHALL toggle on each beep_tick while in RING, and be 0 in any other state; Buzz forced 0 on entry to RING then toggles.
REQ-029 Timers SHALL be 9 bits, unsigned, never wrap below 0.
REQ-030 SnzCnt SHALL saturate at MAX_SNOOZE.

Reset
REQ-031 Reset high at a masCLK edge SHALL set state IDLE, both timers 0, Ring=0, Buzz=0, Snoozing=0, SnzCnt=0, Missed=0, regardless of state or other inputs.
REQ-032 Reset mid-RING or mid-SNOOZE SHALL abort the event; no re-trigger until the next matching sec==0 tick.

Structure
REQ-033 SHALL take state encoding, RING_TIMEOUT_S, SNOOZE_S, MAX_SNOOZE defaults from shared package alarm_pkg.
REQ-034 SHALL use one sub-module sec_countdown (load, tick_1s decrement, zero flag), instantiated twice (ring, snooze).

Verification
REQ-035 Time 07:30:00, alarm 07:30, Alarm_ON=1, tick_1s -> Ring=1 next cycle; after 60 ticks with no buttons -> Ring=0, Missed=1.
REQ-036 Ringing, Snooze pulse -> Snoozing=1, SnzCnt=1, Buzz=0; after 300 ticks -> Ring=1, Buzz toggling on beep_tick.
REQ-037 Snooze 3 times, ring again, 4th Snooze -> ignored, Ring stays 1, SnzCnt=3.
REQ-038 Ringing, Stop and Snooze same cycle -> IDLE, Ring=0, SnzCnt=0.
REQ-039 Time=1 at match with sec=0 -> no trigger; Alarm_ON dropped during SNOOZE -> IDLE next cycle.
REQ-040 Reset asserted during RING at timer=25 -> all outputs 0 next cycle; further ticks within 07:30 give no trigger.
